// File: rtl/counter_ctrl.sv
// Command sequencer for a 4-bit loadable up-counter: accepts HOLD/LOAD/STEP/LOAD_STEP
// commands, drives load/count/din, tallies wraps. Optional abort via COUNTER_CTRL_ABORT_EN.
module counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cnt_load,
  output logic              cnt_count,
  output logic [WIDTH-1:0]  cnt_din,
  input  logic [WIDTH-1:0]  cnt_value,
  input  logic              cnt_carry,
  output logic              busy,
  output logic              done,
  output logic [3:0]        wrap_cnt
`ifdef COUNTER_CTRL_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [1:0]        OP_HOLD      = 2'b00;
  localparam logic [1:0]        OP_LOAD      = 2'b01;
  localparam logic [1:0]        OP_STEP      = 2'b10;
  localparam logic [1:0]        OP_LOAD_STEP = 2'b11;
  localparam logic [STEP_W-1:0] STEP_ONE     = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO    = '0;

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [STEP_W-1:0] steps_q;
  logic              accept;
  logic              abort_hit;

  // The counter reports its value only for observability; control uses c_out alone.
  logic unused_value;
  assign unused_value = ^cnt_value;

`ifdef COUNTER_CTRL_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort & ((state == LOAD) | (state == RUN));
  assign aborted   = (state == DONE) & aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) & ~clear;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign cnt_load  = (state == LOAD) & ~abort_hit;
  assign cnt_count = (state == RUN) & ~abort_hit;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_HOLD:      state_next = DONE;
            OP_LOAD:      state_next = LOAD;
            OP_LOAD_STEP: state_next = LOAD;
            OP_STEP:      state_next = (cmd_steps != STEP_ZERO) ? RUN : DONE;
            default:      state_next = DONE;
          endcase
        end
      end
      LOAD: begin
        if (!abort_hit && op_q == OP_LOAD_STEP && steps_q != STEP_ZERO)
          state_next = RUN;
        else
          state_next = DONE;
      end
      RUN: begin
        if (abort_hit || steps_q == STEP_ONE)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A carry seen while counting means the counter wraps to zero on this edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      op_q     <= OP_HOLD;
      steps_q  <= STEP_ZERO;
      cnt_din  <= '0;
      wrap_cnt <= 4'd0;
`ifdef COUNTER_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        op_q     <= cmd_op;
        steps_q  <= cmd_steps;
        wrap_cnt <= 4'd0;
        if (cmd_op[0])
          cnt_din <= cmd_data;
      end else if (state == RUN && !abort_hit) begin
        steps_q <= steps_q - STEP_ONE;
        if (cnt_carry && wrap_cnt != 4'hF)
          wrap_cnt <= wrap_cnt + 4'd1;
      end
`ifdef COUNTER_CTRL_ABORT_EN
      if (accept)
        aborted_q <= 1'b0;
      else if (abort_hit)
        aborted_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: table vectors, clear/abort corner sequences and
// randomized commands checked against an arithmetic model of the sequencer and counter.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_steps;
  logic       cnt_load;
  logic       cnt_count;
  logic [3:0] cnt_din;
  logic [3:0] cnt_value;
  logic       cnt_carry;
  logic       busy;
  logic       done;
  logic [3:0] wrap_cnt;
`ifdef COUNTER_CTRL_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .cnt_load  (cnt_load),
    .cnt_count (cnt_count),
    .cnt_din   (cnt_din),
    .cnt_value (cnt_value),
    .cnt_carry (cnt_carry),
    .busy      (busy),
    .done      (done),
    .wrap_cnt  (wrap_cnt)
`ifdef COUNTER_CTRL_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  // The 4-bit loadable up-counter the controller drives, with its own reset.
  logic [3:0] cval;
  logic       ctr_reset;
  always_ff @(posedge clk) begin
    if (ctr_reset)      cval <= 4'd0;
    else if (cnt_load)  cval <= cnt_din;
    else if (cnt_count) cval <= cval + 4'd1;
  end
  assign cnt_value = cval;
  assign cnt_carry = (cval == 4'hF);

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] din_expect;
  logic [3:0] ctr_expect;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] steps;
    logic [3:0] exp_wrap;
    logic [3:0] exp_final;
  } vec_t;

  vec_t vec_table [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: starting value plus number of increments gives wraps and final value directly.
  function automatic void refModel(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                                   input logic [3:0] start, output logic [3:0] w, output logic [3:0] f);
    int v0;
    int n;
    int total;
    v0    = op[0] ? int'(data) : int'(start);
    n     = op[1] ? int'(steps) : 0;
    total = v0 + n;
    w     = (total / 16 > 15) ? 4'd15 : 4'(total / 16);
    f     = 4'(total % 16);
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                               input logic [3:0] exp_wrap, input logic [3:0] exp_final);
    int has_load;
    int n;
    int len;
    int waited;
    logic e_load;
    logic e_count;
    logic e_done;
    has_load = op[0] ? 1 : 0;
    n        = op[1] ? int'(steps) : 0;
    len      = has_load + n + 1;
    waited   = 0;
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (has_load == 1) din_expect = data;
      e_load  = (has_load == 1) && (k == 1);
      e_count = (k > has_load) && (k <= has_load + n);
      e_done  = (k == len);
      checkOutput($sformatf("cycle%0d_op%0d", k, op),
                  32'({cnt_load, cnt_count, cnt_din, done, busy, cmd_ready}),
                  32'({e_load, e_count, din_expect, e_done, 1'b1, 1'b0}));
      // Garbage commands while busy must be ignored.
      if (k < len) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_steps = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("idle_after_done", 32'({busy, done, cmd_ready}), 32'b001);
    checkOutput("wrap_cnt", 32'(wrap_cnt), 32'(exp_wrap));
    checkOutput("counter_value", 32'(cval), 32'(exp_final));
    ctr_expect = exp_final;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] r_op;
    logic [3:0] r_data;
    logic [7:0] r_steps;
    logic [3:0] r_wrap;
    logic [3:0] r_final;

    vec_table[0] = '{2'b01, 4'hA, 8'd0,   4'd0,  4'hA};
    vec_table[1] = '{2'b11, 4'hE, 8'd5,   4'd1,  4'h3};
    vec_table[2] = '{2'b10, 4'h9, 8'd0,   4'd0,  4'h3};
    vec_table[3] = '{2'b00, 4'h7, 8'd9,   4'd0,  4'h3};
    vec_table[4] = '{2'b11, 4'h0, 8'd255, 4'd15, 4'hF};
    vec_table[5] = '{2'b10, 4'h6, 8'd20,  4'd2,  4'h3};
    vec_table[6] = '{2'b01, 4'h5, 8'd200, 4'd0,  4'h5};
    vec_table[7] = '{2'b10, 4'h1, 8'd1,   4'd0,  4'h6};
    vec_table[8] = '{2'b11, 4'hF, 8'd1,   4'd1,  4'h0};

    clear     = 1'b1;
    ctr_reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    cmd_steps = 8'd0;
`ifdef COUNTER_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
                32'({cnt_load, cnt_count, cnt_din, done, busy, cmd_ready, wrap_cnt}), 32'd0);
    clear     = 1'b0;
    ctr_reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
    din_expect = 4'h0;
    ctr_expect = 4'h0;

    for (int i = 0; i < 9; i++)
      applyStimulus(vec_table[i].op, vec_table[i].data, vec_table[i].steps,
                    vec_table[i].exp_wrap, vec_table[i].exp_final);

    // STEP 10 abandoned by clear during the 4th count cycle.
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_steps = 8'd10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput($sformatf("clear_seq_count%0d", k), 32'({cnt_count, busy}), 32'b11);
    end
    clear = 1'b1;
    #1;
    checkOutput("ready_low_in_clear", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("state_after_clear",
                32'({cnt_load, cnt_count, cnt_din, done, busy, wrap_cnt}), 32'd0);
    clear = 1'b0;
    #1;
    checkOutput("ready_after_clear", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("no_done_after_clear", 32'({done, busy}), 32'b00);
    end
    ctr_expect = ctr_expect + 4'd4;
    din_expect = 4'h0;
    checkOutput("counter_after_clear", 32'(cval), 32'(ctr_expect));

`ifdef COUNTER_CTRL_ABORT_EN
    applyStimulus(2'b01, 4'hE, 8'd0, 4'd0, 4'hE);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_steps = 8'd10;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput($sformatf("abort_seq_count%0d", k), 32'(cnt_count), 32'd1);
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    checkOutput("abort_gates_count", 32'({cnt_count, busy}), 32'b01);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_done_pulse", 32'({done, aborted}), 32'b11);
    @(negedge clk);
    checkOutput("after_abort_idle", 32'({busy, done, aborted}), 32'b000);
    checkOutput("abort_wrap_kept", 32'(wrap_cnt), 32'd1);
    checkOutput("abort_two_counts", 32'(cval), 32'h0);
    ctr_expect = 4'h0;
`endif

    for (int i = 0; i < 25; i++) begin
      r_op    = 2'($urandom);
      r_data  = 4'($urandom);
      r_steps = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      refModel(r_op, r_data, r_steps, ctr_expect, r_wrap, r_final);
      applyStimulus(r_op, r_data, r_steps, r_wrap, r_final);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
